// File: rtl/f3_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : f3_ctrl_if
//  Purpose  : Bundles the F3 sequencer's write-side and read-side handshake
//             signals. The sequencer connects through the slave modport; the
//             pixel source / C3 engine side uses the master modport.
//  Signals  : wr_in_vld, f3_wr_en, f3_waddr, wr_frame_done, f3_full,
//             rd_start, rd_stall, rd_busy, f3_raddr, rd_vld, rd_win_last,
//             rd_done, ovf_err
//  Revision : 1.0  initial release
// ============================================================================
interface f3_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              wr_in_vld;
    logic              f3_wr_en;
    logic [ADDR_W-1:0] f3_waddr;
    logic              wr_frame_done;
    logic              f3_full;
    logic              rd_start;
    logic              rd_stall;
    logic              rd_busy;
    logic [ADDR_W-1:0] f3_raddr;
    logic              rd_vld;
    logic              rd_win_last;
    logic              rd_done;
    logic              ovf_err;

    modport slave (
        input  wr_in_vld, rd_start, rd_stall,
        output f3_wr_en, f3_waddr, wr_frame_done, f3_full,
               rd_busy, f3_raddr, rd_vld, rd_win_last, rd_done, ovf_err
    );

    modport master (
        output wr_in_vld, rd_start, rd_stall,
        input  f3_wr_en, f3_waddr, wr_frame_done, f3_full,
               rd_busy, f3_raddr, rd_vld, rd_win_last, rd_done, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/f3_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : f3_ctrl
//  Purpose  : Address sequencer for the single-buffered 6-channel F3 feature
//             map RAM. Fills one MAP_W x MAP_W frame from the pooled pixel
//             stream, then scans every KER x KER window (kx innermost, oy
//             outermost) issuing one read address per unstalled cycle with a
//             valid flag aligned to the RAM read data. The end of the scan
//             releases the buffer for the next fill.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - f3_ctrl_if.slave: write strobe/address, frame status,
//                      scan control, read address/valid/last/done, ovf_err
//  Config   : F3_OVF_CHK_EN - when defined, a pixel arriving while the frame
//                      is full sets the sticky ovf_err flag; otherwise
//                      ovf_err is tied low and such pixels are dropped silently.
//  Revision : 1.0  initial release
// ============================================================================
module f3_ctrl #(
    parameter int MAP_W  = 14,
    parameter int KER    = 5,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input wire logic   clk,
    input wire logic   rst_n,
    f3_ctrl_if.slave   bus
);
    localparam int OUT_W = MAP_W - KER + 1;
    localparam int OW    = $clog2(OUT_W + 1);
    localparam int KW    = $clog2(KER + 1);
    localparam int DW    = $clog2(RD_LAT + 1) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_W * MAP_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(MAP_W);
    localparam logic [OW-1:0]     OMAX      = OW'(OUT_W - 1);
    localparam logic [KW-1:0]     KMAX      = KW'(KER - 1);
    localparam logic [DW-1:0]     DRAIN_END = DW'(RD_LAT);

    typedef enum logic [0:0] {W_FILL = 1'b0, W_FULL = 1'b1} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_RUN = 2'd1, R_DRAIN = 2'd2} rstate_t;

    // ---------------- write side ----------------
    wstate_t           r_wstate, w_wstate_nxt;
    logic [ADDR_W-1:0] r_wcnt, w_wcnt_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              w_wr_en;
    logic              w_release;

    // ---------------- read side -----------------
    rstate_t           r_rstate, w_rstate_nxt;
    logic [DW-1:0]     r_dcnt, w_dcnt_nxt;
    logic              r_rd_done;
    logic              w_issue;
    logic [OW-1:0]     r_oy, r_ox;
    logic [KW-1:0]     r_ky, r_kx;
    logic [ADDR_W-1:0] r_win_row;   // oy * MAP_W
    logic [ADDR_W-1:0] r_tap_row;   // (oy + ky) * MAP_W
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] w_addr;
    logic              w_tap_last, w_scan_end;
    logic              r_issued, r_issued_last;
    logic [RD_LAT-1:0] r_vld_pipe, r_last_pipe;

    // The rd_done cycle is the release cycle: the buffer already reads as
    // empty, but a pixel arriving in that exact cycle is dropped. rst_n keeps
    // the strobe low while reset is asserted.
    assign w_wr_en = bus.wr_in_vld & (r_wstate == W_FILL) & ~r_rd_done & rst_n;

    always_comb begin
        w_wstate_nxt     = r_wstate;
        w_wcnt_nxt       = r_wcnt;
        w_frame_done_nxt = 1'b0;
        if (w_release) begin
            w_wstate_nxt = W_FILL;
            w_wcnt_nxt   = '0;
        end else if (w_wr_en) begin
            if (r_wcnt == LAST_ADDR) begin
                w_wstate_nxt     = W_FULL;
                w_frame_done_nxt = 1'b1;
            end else begin
                w_wcnt_nxt = r_wcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate     <= W_FILL;
            r_wcnt       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_wstate     <= w_wstate_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // ---------------- read FSM ----------------
    assign w_tap_last = (r_ky == KMAX) && (r_kx == KMAX);
    assign w_scan_end = w_tap_last && (r_oy == OMAX) && (r_ox == OMAX);
    assign w_addr     = r_tap_row + ADDR_W'(r_ox) + ADDR_W'(r_kx);

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_dcnt_nxt   = r_dcnt;
        w_issue      = 1'b0;
        w_release    = 1'b0;
        case (r_rstate)
            // The start cycle itself issues the first address (unless stalled).
            R_IDLE: begin
                if (bus.rd_start && (r_wstate == W_FULL)) begin
                    w_rstate_nxt = R_RUN;
                    w_issue      = ~bus.rd_stall;
                end
            end
            R_RUN: w_issue = ~bus.rd_stall;
            // Hold until the last issued read has come back, then release.
            R_DRAIN: begin
                if (r_dcnt == DRAIN_END) begin
                    w_rstate_nxt = R_IDLE;
                    w_release    = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        if (w_issue && w_scan_end) begin
            w_rstate_nxt = R_DRAIN;
            w_dcnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_dcnt    <= '0;
            r_rd_done <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_rd_done <= w_release;
        end
    end

    // Window counters; row bases advance by MAP_W instead of multiplying.
    // After the final tap every counter wraps to zero, ready for the next scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oy      <= '0;
            r_ox      <= '0;
            r_ky      <= '0;
            r_kx      <= '0;
            r_win_row <= '0;
            r_tap_row <= '0;
            r_raddr   <= '0;
        end else if (w_issue) begin
            r_raddr <= w_addr;
            if (r_kx != KMAX) begin
                r_kx <= r_kx + 1'b1;
            end else begin
                r_kx <= '0;
                if (r_ky != KMAX) begin
                    r_ky      <= r_ky + 1'b1;
                    r_tap_row <= r_tap_row + ROW_STEP;
                end else begin
                    r_ky <= '0;
                    if (r_ox != OMAX) begin
                        r_ox      <= r_ox + 1'b1;
                        r_tap_row <= r_win_row;
                    end else begin
                        r_ox <= '0;
                        if (r_oy != OMAX) begin
                            r_oy      <= r_oy + 1'b1;
                            r_win_row <= r_win_row + ROW_STEP;
                            r_tap_row <= r_win_row + ROW_STEP;
                        end else begin
                            r_oy      <= '0;
                            r_win_row <= '0;
                            r_tap_row <= '0;
                        end
                    end
                end
            end
        end
    end

    // r_issued is aligned with f3_raddr; RD_LAT more stages align it with data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued      <= 1'b0;
            r_issued_last <= 1'b0;
            r_vld_pipe    <= '0;
            r_last_pipe   <= '0;
        end else begin
            r_issued       <= w_issue;
            r_issued_last  <= w_issue & w_tap_last;
            r_vld_pipe[0]  <= r_issued;
            r_last_pipe[0] <= r_issued_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

`ifdef F3_OVF_CHK_EN
    logic r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (bus.wr_in_vld && (r_wstate == W_FULL)) begin
            r_ovf <= 1'b1;
        end
    end
    assign bus.ovf_err = r_ovf;
`else
    assign bus.ovf_err = 1'b0;
`endif

    assign bus.f3_wr_en      = w_wr_en;
    assign bus.f3_waddr      = r_wcnt;
    assign bus.wr_frame_done = r_frame_done;
    assign bus.f3_full       = (r_wstate == W_FULL);
    assign bus.rd_busy       = (r_rstate != R_IDLE);
    assign bus.f3_raddr      = r_raddr;
    assign bus.rd_vld        = r_vld_pipe[RD_LAT-1];
    assign bus.rd_win_last   = r_last_pipe[RD_LAT-1];
    assign bus.rd_done       = r_rd_done;
endmodule
`default_nettype wire

// File: tb/tb_f3_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_f3_ctrl
//  Purpose  : Self-checking bench for f3_ctrl: randomized pixel and stall
//             stimulus against a window-scan reference list and an issue log.
//  Revision : 1.0  initial release
// ============================================================================
module tb_f3_ctrl;
    localparam int MAP_W  = 14;
    localparam int KER    = 5;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 1;
    localparam int OUT_W  = MAP_W - KER + 1;
    localparam int NPIX   = MAP_W * MAP_W;
    localparam int NSCAN  = OUT_W * OUT_W * KER * KER;
`ifdef F3_OVF_CHK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    f3_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    f3_ctrl #(.MAP_W(MAP_W), .KER(KER), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    int exp_addr [NSCAN];
    bit exp_last [NSCAN];
    int rh  [8192];
    bit iss [8192];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_drive();
        @(posedge clk);
        #1;
    endtask

    // Fill until NPIX pixels are accepted (n0 already accepted), then check
    // the frame_done pulse, full flag and drop of an extra pixel.
    task automatic fill_frame(input int n0);
        int n;
        int cyc;
        n = n0;
        cyc = 0;
        while (n < NPIX && cyc < 5000) begin
            cyc_drive();
            bus.wr_in_vld = ($urandom_range(0, 2) != 0);
            #1;
            check("wr_en", bus.f3_wr_en, bus.wr_in_vld);
            if (bus.wr_in_vld) begin
                check("waddr", bus.f3_waddr, n);
                n++;
            end
            check("frame_done_early", bus.wr_frame_done, 0);
            check("full_early", bus.f3_full, 0);
            cyc++;
        end
        if (n < NPIX) check("fill_timeout", n, NPIX);
        cyc_drive();
        bus.wr_in_vld = 1'b1;
        #1;
        check("frame_done", bus.wr_frame_done, 1);
        check("full_set", bus.f3_full, 1);
        check("wr_en_when_full", bus.f3_wr_en, 0);
        check("waddr_hold", bus.f3_waddr, NPIX - 1);
        cyc_drive();
        bus.wr_in_vld = 1'b0;
        #1;
        check("frame_done_pulse", bus.wr_frame_done, 0);
        check("waddr_hold2", bus.f3_waddr, NPIX - 1);
        check("ovf_err", bus.ovf_err, OVF_EN);
    endtask

    // Window scan with random stalls, one forced 7-cycle mid-window stall,
    // a rejected restart, and the release-cycle write check at the end.
    task automatic run_scan();
        int c, issued, jdone, vcnt, lcnt, k, force_left;
        bit forced, exp_vld;
        issued = 0; jdone = -1; vcnt = 0; lcnt = 0; k = 0;
        force_left = 0; forced = 0;
        for (c = 0; c < 8000; c++) begin
            cyc_drive();
            bus.rd_start = (c == 0 || c == 300);
            if (force_left > 0) begin
                bus.rd_stall = 1'b1;
                force_left--;
            end else if (!forced && c > 0 && issued >= 1200 && (issued % 25) == 12) begin
                forced = 1'b1;
                force_left = 6;
                bus.rd_stall = 1'b1;
            end else begin
                bus.rd_stall = (c > 0 && issued < NSCAN && $urandom_range(0, 9) < 2);
            end
            bus.wr_in_vld = (jdone >= 0 && c >= jdone) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            rh[c] = int'(bus.f3_raddr);
            exp_vld = (c >= 1 + RD_LAT) ? iss[c-1-RD_LAT] : 1'b0;
            check("rd_vld", bus.rd_vld, exp_vld);
            if (bus.rd_vld) begin
                vcnt++;
                if (bus.rd_win_last) lcnt++;
            end
            if (exp_vld && k < NSCAN) begin
                check("raddr", rh[c-RD_LAT], exp_addr[k]);
                check("win_last", bus.rd_win_last, exp_last[k]);
                k++;
            end else begin
                check("win_last_idle", bus.rd_win_last, 0);
            end
            if (c >= 2 && !iss[c-1]) check("raddr_frozen", bus.f3_raddr, rh[c-1]);
            check("rd_done", bus.rd_done, (jdone >= 0 && c == jdone));
            check("rd_busy", bus.rd_busy, (c >= 1 && (jdone < 0 || c < jdone)));
            check("f3_full_scan", bus.f3_full, (jdone < 0 || c < jdone));
            if (jdone >= 0 && c == jdone) begin
                check("wr_drop_at_release", bus.f3_wr_en, 0);
            end else if (jdone >= 0 && c == jdone + 1) begin
                check("wr_en_after_release", bus.f3_wr_en, 1);
                check("waddr_after_release", bus.f3_waddr, 0);
                break;
            end else begin
                check("wr_en_while_full", bus.f3_wr_en, 0);
            end
            iss[c] = (!bus.rd_stall && issued < NSCAN);
            if (iss[c]) begin
                issued++;
                if (issued == NSCAN) jdone = c + RD_LAT + 2;
            end
        end
        if (!(jdone >= 0 && c == jdone + 1)) check("scan_timeout", c, jdone + 1);
        check("rd_vld_count", vcnt, NSCAN);
        check("win_last_count", lcnt, OUT_W * OUT_W);
        check("forced_stall_seen", forced, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_f3_wr_en"}, bus.f3_wr_en, 0);
        check({tag, "_f3_waddr"}, bus.f3_waddr, 0);
        check({tag, "_frame_done"}, bus.wr_frame_done, 0);
        check({tag, "_f3_full"}, bus.f3_full, 0);
        check({tag, "_rd_busy"}, bus.rd_busy, 0);
        check({tag, "_f3_raddr"}, bus.f3_raddr, 0);
        check({tag, "_rd_vld"}, bus.rd_vld, 0);
        check({tag, "_rd_win_last"}, bus.rd_win_last, 0);
        check({tag, "_rd_done"}, bus.rd_done, 0);
        check({tag, "_ovf_err"}, bus.ovf_err, 0);
    endtask

    initial begin
        int k;
        k = 0;
        for (int oy = 0; oy < OUT_W; oy++)
            for (int ox = 0; ox < OUT_W; ox++)
                for (int ky = 0; ky < KER; ky++)
                    for (int kx = 0; kx < KER; kx++) begin
                        exp_addr[k] = (oy + ky) * MAP_W + (ox + kx);
                        exp_last[k] = (ky == KER - 1) && (kx == KER - 1);
                        k++;
                    end

        bus.wr_in_vld = 1'b0;
        bus.rd_start  = 1'b0;
        bus.rd_stall  = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc_drive();
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Start request with no frame stored is ignored.
        cyc_drive();
        bus.rd_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc_drive();
            bus.rd_start = 1'b0;
            #1;
            check("idle_busy", bus.rd_busy, 0);
            check("idle_vld", bus.rd_vld, 0);
            check("idle_raddr", bus.f3_raddr, 0);
        end

        fill_frame(0);
        run_scan();
        fill_frame(1);

        // Reset asserted in the middle of a scan.
        cyc_drive();
        bus.rd_start = 1'b1;
        bus.wr_in_vld = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cyc_drive();
            bus.rd_start = 1'b0;
            bus.rd_stall = 1'b0;
        end
        #1;
        check("busy_before_reset", bus.rd_busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) cyc_drive();
        rst_n = 1'b1;
        cyc_drive();
        bus.wr_in_vld = 1'b1;
        #1;
        check("refill_wr_en", bus.f3_wr_en, 1);
        check("refill_waddr0", bus.f3_waddr, 0);
        cyc_drive();
        bus.wr_in_vld = 1'b0;
        #1;
        check("refill_waddr1", bus.f3_waddr, 1);
        check("refill_full", bus.f3_full, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
